// File: rtl/rd_pkg.sv
// Purpose: shared types, default parameters and width helper for the route distributor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rd_state_e;

    localparam int DEF_DIN_W  = 70;
    localparam int DEF_SLOT_N = 128;
    localparam int DEF_STEP   = 8;

    // Bits needed to hold any count in 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rd_step_cell.sv
// Purpose: resolve one STEP-wide chunk of slots; each enabled slot takes the next data lane.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   mask  - slot-enable bits for this chunk
//   base  - number of lanes already consumed by lower chunks
//   din   - full lane vector
//   dout  - resolved slot values for this chunk (1 where disabled or lanes exhausted)
//   pop   - number of enabled slots in this chunk
module rd_step_cell
    import rd_pkg::*;
#(
    parameter int DIN_W  = DEF_DIN_W,
    parameter int STEP   = DEF_STEP,
    parameter int BASE_W = 8,
    parameter int POP_W  = 4
) (
    input  logic [STEP-1:0]   mask,
    input  logic [BASE_W-1:0] base,
    input  logic [DIN_W-1:0]  din,
    output logic [STEP-1:0]   dout,
    output logic [POP_W-1:0]  pop
);

    // Lane index can reach base + STEP; size the lookup so every reachable
    // index is in range and lanes at or beyond DIN_W read back as idle fill.
    localparam int K_W   = cnt_w((2 ** BASE_W) + STEP);
    localparam int LANES = 2 ** K_W;

    logic [LANES-1:0] din_ext;

    for (genvar i = 0; i < LANES; i++) begin : g_ext
        if (i < DIN_W) begin : g_lane
            assign din_ext[i] = din[i];
        end else begin : g_fill
            assign din_ext[i] = 1'b1;
        end
    end

    logic [K_W-1:0] k;

    always_comb begin
        k    = K_W'(base);
        pop  = '0;
        dout = '1;
        for (int j = 0; j < STEP; j++) begin
            if (mask[j]) begin
                dout[j] = din_ext[k];
            end
            k   = k + K_W'(mask[j]);
            pop = pop + POP_W'(mask[j]);
        end
    end

endmodule

// File: rtl/route_distributor_seq.sv
// Purpose: distribute data lanes onto enabled output slots, STEP slots per clock.
// Latency: SLOT_N/STEP + 1 rising edges from accept to out_valid (17 at defaults).
// Backpressure: one request in flight; in_ready low until the result is taken via out_ready.
//
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   in_valid/in_ready       - request handshake carrying din and sw_mask
//   din                     - lane data, lane 0 goes to the lowest enabled slot
//   sw_mask                 - slot enables
//   out_valid/out_ready     - result handshake
//   dout                    - distributed slot vector (held while out_valid)
//   err_underflow/overflow  - fewer / more enabled slots than lanes, valid with out_valid
//   busy                    - request in progress
module route_distributor_seq
    import rd_pkg::*;
#(
    parameter int DIN_W  = DEF_DIN_W,
    parameter int SLOT_N = DEF_SLOT_N,
    parameter int STEP   = DEF_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_W-1:0]  din,
    input  logic [SLOT_N-1:0] sw_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SLOT_N-1:0] dout,
    output logic              err_underflow,
    output logic              err_overflow,
    output logic              busy
);

    localparam int N_STEPS = SLOT_N / STEP;
    localparam int CNT_W   = cnt_w(SLOT_N);
    localparam int POP_W   = cnt_w(STEP);
    localparam int IDX_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

    if (SLOT_N % STEP != 0) begin : g_bad_step
        $error("route_distributor_seq: SLOT_N must be a multiple of STEP");
    end

    rd_state_e state, state_nxt;

    logic [DIN_W-1:0]                din_q;
    logic [SLOT_N-1:0]               mask_q;
    logic [IDX_W-1:0]                idx_q;
    logic [CNT_W-1:0]                cnt_q;
    logic                            ovf_q;
    logic [N_STEPS-1:0][STEP-1:0]    dout_q;
    logic [N_STEPS-1:0][STEP-1:0]    mask_c;

    logic [STEP-1:0]  chunk_dout;
    logic [POP_W-1:0] chunk_pop;
    logic [31:0]      lane_sum;
    logic             accept;
    logic             last_step;

    assign mask_c    = mask_q;
    assign dout      = dout_q;
    assign accept    = in_valid && in_ready;
    assign last_step = (idx_q == IDX_W'(N_STEPS - 1));
    assign lane_sum  = 32'(cnt_q) + 32'(chunk_pop);

    rd_step_cell #(
        .DIN_W  (DIN_W),
        .STEP   (STEP),
        .BASE_W (CNT_W),
        .POP_W  (POP_W)
    ) u_cell (
        .mask (mask_c[idx_q]),
        .base (cnt_q),
        .din  (din_q),
        .dout (chunk_dout),
        .pop  (chunk_pop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b1;
        err_underflow = 1'b0;
        err_overflow  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_step) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // The counter saturates at DIN_W, so "more than DIN_W" is
                // remembered separately in ovf_q.
                err_overflow  = ovf_q;
                err_underflow = !ovf_q && (32'(cnt_q) < 32'(DIN_W));
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q  <= '0;
            mask_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            dout_q <= '1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        din_q  <= din;
                        mask_q <= sw_mask;
                        idx_q  <= '0;
                        cnt_q  <= '0;
                        ovf_q  <= 1'b0;
                        dout_q <= '1;
                    end
                end
                ST_RUN: begin
                    dout_q[idx_q] <= chunk_dout;
                    idx_q         <= idx_q + IDX_W'(1);
                    if (lane_sum > 32'(DIN_W)) begin
                        cnt_q <= CNT_W'(DIN_W);
                        ovf_q <= 1'b1;
                    end else begin
                        cnt_q <= CNT_W'(lane_sum);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
